fsm_step_ctrl: RTL

Upstream input stage for easy_fpga_state_machine, producing the single-cycle step pulse that advances the display FSM.
- Synchronises and debounces the active-low board push-button and the auto/manual slide switch.
- In auto mode, also generates periodic steps from a free-running timer derived from CLOCK_FREQ.
- Output is one clean, glitch-free step source the FSM consumes directly.

---
 rtl/fsm_step_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fsm_step_ctrl.sv
// fsm_step_ctrl: input stage that feeds the display FSM with one clean step
// pulse. Synchronises and debounces the active-low push-button, synchronises
// the auto/manual slide switch and, in auto mode, adds periodic steps from a
// free-running timer.
//
// Optional feature macro: STEP_REPEAT_EN
//   defined   - in manual mode the step timer also runs while the debounced
//               key is held low, giving hold-to-repeat steps.
//   undefined - in manual mode each press yields exactly one step.
//
// Handshake: none. o_step is a one-cycle strobe; the consumer must act on it
// in the cycle it is high. Every output comes straight from a flop, so there
// is no combinational path from any input to any output.
module fsm_step_ctrl #(
    parameter logic [31:0] CLOCK_FREQ     = 32'd50_000_000,
    parameter int          DEBOUNCE_MS    = 20,
    parameter int          STEP_PERIOD_MS = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key_n,
    input  logic i_auto_sw,
    output logic o_step,
    output logic o_auto,
    output logic o_key_db
);

    localparam int unsigned DEB_CYC  = CLOCK_FREQ / 1000 * DEBOUNCE_MS;
    localparam int unsigned STEP_CYC = CLOCK_FREQ / 1000 * STEP_PERIOD_MS;

    // A one-cycle debounce window still needs a 1-bit counter.
    localparam int DEB_W  = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam int STEP_W = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;

    localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEB_CYC - 1);
    localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(STEP_CYC - 1);

    if (DEB_CYC < 1) begin : g_bad_deb
        $error("fsm_step_ctrl: debounce window must be at least one cycle");
    end
    if (STEP_CYC < 2) begin : g_bad_step
        $error("fsm_step_ctrl: step period must be at least two cycles");
    end

    logic              key_s1;
    logic              key_s2;
    logic              sw_s1;
    logic              sw_s2;
    logic              key_db;
    logic              key_db_d;
    logic [DEB_W-1:0]  deb_cnt;
    logic [STEP_W-1:0] timer;
    logic              step_q;
    logic              press;
    logic              timer_run;
    logic              wrap;

    // Two-flop synchronisers; the key idles released (1), the switch idles manual (0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1 <= 1'b1;
            key_s2 <= 1'b1;
            sw_s1  <= 1'b0;
            sw_s2  <= 1'b0;
        end else begin
            key_s1 <= i_key_n;
            key_s2 <= key_s1;
            sw_s1  <= i_auto_sw;
            sw_s2  <= sw_s1;
        end
    end

    // Debounce: accept a new key level only after it has differed for DEB_CYC cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_db  <= 1'b1;
            deb_cnt <= '0;
        end else if (key_s2 == key_db) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_MAX) begin
            key_db  <= key_s2;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    // Delayed copy of the debounced level for falling-edge (press) detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_db_d <= 1'b1;
        end else begin
            key_db_d <= key_db;
        end
    end

    // Press is the debounced 1 -> 0 transition; release produces nothing.
    assign press = key_db_d & ~key_db;

`ifdef STEP_REPEAT_EN
    assign timer_run = sw_s2 | ~key_db;
`else
    assign timer_run = sw_s2;
`endif

    assign wrap = timer_run && (timer == STEP_MAX);

    // Step timer: idle at 0 when not running; a press restarts the period so
    // a manual step is never followed closely by an auto step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (!timer_run || press || wrap) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // Registered step: press and wrap in the same cycle merge into one pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q <= 1'b0;
        end else begin
            step_q <= press | wrap;
        end
    end

    assign o_step   = step_q;
    assign o_auto   = sw_s2;
    assign o_key_db = key_db;

endmodule
